// File: rtl/aes_block_loader.sv
// Staging stage for aes_core: packs eight 32-bit words into key/plaintext, starts the core,
// waits for done with a timeout, and hands the ciphertext out. Optional: AES_LOADER_ZEROIZE_EN.
module aes_block_loader #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         abort,
    output logic         core_start,
    output logic [127:0] core_key,
    output logic [127:0] core_plaintext,
    input  logic         core_done,
    input  logic [127:0] core_ciphertext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         error
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_LOAD, ST_START, ST_WAIT, ST_OUTPUT, ST_CLEAR
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          word_cnt_reg;
    logic [127:0]        key_reg, pt_reg, out_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic                error_reg;
    logic                accept;
    logic                timeout;
    logic [3:0]          key_we, pt_we;

    // A word presented together with abort is dropped, never accepted.
    assign accept  = (state_reg == ST_LOAD) && in_valid && !abort;
    assign timeout = (wait_cnt_reg == WAIT_LAST);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word_we
            assign key_we[gi] = accept && !word_cnt_reg[2] && (word_cnt_reg[1:0] == 2'(gi));
            assign pt_we[gi]  = accept &&  word_cnt_reg[2] && (word_cnt_reg[1:0] == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_LOAD;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD:   if (accept && word_cnt_reg == 3'd7) state_next = ST_START;
            ST_START:  state_next = abort ? ST_CLEAR : ST_WAIT;
            ST_WAIT: begin
                if (abort)          state_next = ST_CLEAR;
                else if (core_done) state_next = ST_OUTPUT;
                else if (timeout)   state_next = ST_CLEAR;
            end
            ST_OUTPUT: if (out_ready) state_next = ST_CLEAR;
            ST_CLEAR:  state_next = ST_LOAD;
            default:   state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_START:  core_start = 1'b1;
            ST_OUTPUT: out_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_reg <= '0;
            key_reg      <= '0;
            pt_reg       <= '0;
            out_reg      <= '0;
            wait_cnt_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (abort) begin
                        word_cnt_reg <= '0;
                    end else if (accept) begin
                        word_cnt_reg <= word_cnt_reg + 3'd1;
                        for (int i = 0; i < 4; i++) begin
                            if (key_we[i]) key_reg[127-32*i -: 32] <= in_data;
                            if (pt_we[i])  pt_reg[127-32*i -: 32]  <= in_data;
                        end
                    end
                end
                ST_START: wait_cnt_reg <= '0;
                ST_WAIT: begin
                    if (!abort) begin
                        if (core_done)    out_reg      <= core_ciphertext;
                        else if (timeout) error_reg    <= 1'b1;
                        else              wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    word_cnt_reg <= '0;
`ifdef AES_LOADER_ZEROIZE_EN
                    key_reg <= '0;
                    pt_reg  <= '0;
                    out_reg <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign core_key       = key_reg;
    assign core_plaintext = pt_reg;
    assign out_data       = out_reg;
    assign error          = error_reg;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: table of jobs plus abort, timeout and reset sequences,
// with a behavioural core stub that raises done 12 edges after it samples core_start.
module tb_aes_block_loader;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         abort = 1'b0;
    logic         core_start;
    logic [127:0] core_key, core_plaintext;
    logic         core_done;
    logic [127:0] core_ciphertext = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;
    logic         error;

    int checks = 0;
    int errors = 0;
    logic exp_error = 1'b0;
    logic core_en = 1'b1;
    int core_cnt = 0;

    always #5 clk = ~clk;

    aes_block_loader #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .abort(abort),
        .core_start(core_start), .core_key(core_key), .core_plaintext(core_plaintext),
        .core_done(core_done), .core_ciphertext(core_ciphertext),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .error(error)
    );

    // Core stub: counts from the edge that samples core_start, done is a level at count 12.
    always @(posedge clk) begin
        if (core_start) core_cnt <= 1;
        else if (core_cnt != 0 && core_cnt < 12) core_cnt <= core_cnt + 1;
    end
    assign core_done = core_en && (core_cnt == 12);

    typedef struct {
        logic [0:7][31:0] w;
        logic [127:0]     key;
        logic [127:0]     pt;
        logic [127:0]     ct;
        int               hold;
    } vec_t;

    vec_t tab [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int v);
        int n;
        int starts;
        logic stable;
        core_ciphertext = tab[v].ct;
        for (int k = 0; k < 8; k++) send_word(tab[v].w[k]);
        chk("start_pulse", core_start, 1);
        chk("start_in_ready", in_ready, 0);
        chk("start_busy", busy, 1);
        chk("core_key", core_key, tab[v].key);
        chk("core_pt", core_plaintext, tab[v].pt);
        starts = core_start ? 1 : 0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
            if (core_start) starts++;
            if (!out_valid && n == 5) begin
                chk("wait_key", core_key, tab[v].key);
                chk("wait_pt", core_plaintext, tab[v].pt);
            end
        end
        chk("latency", n, 13);
        chk("start_count", starts, 1);
        chk("out_data", out_data, tab[v].ct);
        chk("error_flag", error, exp_error);
        stable = 1'b1;
        for (int h = 0; h < tab[v].hold; h++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== tab[v].ct || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_valid", out_valid, 0);
        chk("clear_in_ready", in_ready, 0);
        tick();
        chk("load_in_ready", in_ready, 1);
        chk("load_busy", busy, 0);
`ifdef AES_LOADER_ZEROIZE_EN
        chk("zeroize_key", core_key, '0);
        chk("zeroize_pt", core_plaintext, '0);
        chk("zeroize_out", out_data, '0);
`else
        chk("retain_key", core_key, tab[v].key);
        chk("retain_pt", core_plaintext, tab[v].pt);
        chk("retain_out", out_data, tab[v].ct);
`endif
        $display("job %0d: latency=%0d starts=%0d out_data=%h", v, n, starts, out_data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_key"}, core_key, '0);
        chk({tag, "_pt"}, core_plaintext, '0);
        chk({tag, "_out_data"}, out_data, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;

        tab[0].w    = {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                       32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        tab[0].key  = 128'h000102030405060708090A0B0C0D0E0F;
        tab[0].pt   = 128'h00112233445566778899AABBCCDDEEFF;
        tab[0].ct   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
        tab[0].hold = 20;
        tab[1].w    = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF,
                       32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A};
        tab[1].key  = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
        tab[1].pt   = 128'hFFFFFFFF00000000A5A5A5A55A5A5A5A;
        tab[1].ct   = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        tab[1].hold = 0;
        tab[2].w    = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                       32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        tab[2].key  = 128'h11111111222222223333333344444444;
        tab[2].pt   = 128'h55555555666666667777777788888888;
        tab[2].ct   = 128'hFEDCBA98765432100123456789ABCDEF;
        tab[2].hold = 3;

        // Reset state
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // Table-driven jobs
        for (int v = 0; v < 3; v++) run_job(v);

        // Abort in LOAD after 5 words; the word offered with abort is dropped
        for (int k = 0; k < 5; k++) send_word(tab[0].w[k]);
        abort = 1'b1;
        send_word(32'hBAD0BAD0);
        abort = 1'b0;
        run_job(2);

        // Abort in WAIT: no output, back to LOAD through CLEAR
        core_ciphertext = tab[1].ct;
        for (int k = 0; k < 8; k++) send_word(tab[1].w[k]);
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_wait_in_ready", in_ready, 0);
        chk("abort_wait_busy", busy, 1);
        tick();
        chk("abort_wait_load", in_ready, 1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_wait_no_output", seen, 0);
        chk("abort_no_error", error, 0);

        // Timeout with a dead core
        core_en = 1'b0;
        for (int k = 0; k < 8; k++) send_word(tab[0].w[k]);
        seen = 1'b0;
        n = 0;
        while (n < 64) begin
            if (out_valid) seen = 1'b1;
            tick();
            n++;
        end
        chk("timeout_not_early", error, 0);
        tick();
        chk("timeout_error", error, 1);
        chk("timeout_no_valid", seen | out_valid, 0);
        tick();
        chk("timeout_back_to_load", in_ready, 1);
        $display("timeout: error=%0d after %0d cycles", error, n + 1);
        core_en = 1'b1;
        exp_error = 1'b1;
        run_job(1);
        chk("error_sticky", error, 1);
        do_reset();
        exp_error = 1'b0;
        chk("error_cleared_by_rst", error, 0);

        // Reset during WAIT
        for (int k = 0; k < 8; k++) send_word(tab[1].w[k]);
        tick(); tick(); tick(); tick();
        chk("pre_rst_busy", busy, 1);
        do_reset();
        chk_reset_state("rst_wait");
        run_job(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
